// File: rtl/pc_unit_pkg.sv
// Package shared by the program-counter unit and its redirect buffer.
// Holds the sequencer state type and the default vector/step constants.
package pc_unit_pkg;

  // BOOT: one idle cycle after reset, no fetch request.
  // RUN : normal sequential fetch.
  // PEND: a branch arrived while fetch could not fire; target is parked.
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } pc_state_e;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_4180;
  localparam int          DEF_STEP      = 4;

endpackage

// File: rtl/pc_redirect_buf.sv
// Pending-redirect register: holds one parked branch target.
// Ports:
//   clk, reset        clock, async active-low reset (clears the entry)
//   set, set_target   park a target (overwrites any older one; wins over clr)
//   clr               drop the parked target
//   valid, target     parked entry
module pc_redirect_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic             clr,
  input  logic [WIDTH-1:0] set_target,
  output logic             valid,
  output logic [WIDTH-1:0] target
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid  <= 1'b0;
      target <= '0;
    end else if (set) begin
      valid  <= 1'b1;
      target <= set_target;
    end else if (clr) begin
      valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: generates the fetch address stream with
// exception entry, exception return and branch redirects. A branch that
// cannot fire (stall or memory not ready) is parked in pc_redirect_buf and
// taken on the next fire.
// Ports:
//   clk, reset              clock, async active-low reset
//   stall                   pipeline hold, blocks sequential/branch advance
//   br_valid, br_target     branch/jump redirect
//   exc_valid               exception entry (to EXC_VEC)
//   eret_valid, epc         exception return (to epc)
//   fetch_ready             instruction memory accepts the fetch
//   fetch_valid             pc holds a fetch request
//   pc, pc_plus             current fetch address and pc+STEP
//   align_err               one-cycle pulse after loading a misaligned pc
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEF_RESET_VEC),
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(DEF_EXC_VEC),
  parameter int               STEP      = DEF_STEP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_target,
  input  logic             exc_valid,
  input  logic             eret_valid,
  input  logic [WIDTH-1:0] epc,
  input  logic             fetch_ready,
  output logic             fetch_valid,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic             align_err
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  pc_state_e        state, st_nxt;
  logic             fire;
  logic             ld;
  logic [WIDTH-1:0] pc_nxt;
  logic             misaligned;
  logic             pend_set, pend_clr, pend_vld;
  logic [WIDTH-1:0] pend_tgt;

  assign fire       = fetch_valid & fetch_ready & ~stall;
  // Natural modulo-2^WIDTH wrap, no carry out.
  assign pc_plus    = pc + STEP_W;
  assign misaligned = (pc_nxt % STEP_W) != '0;

  pc_redirect_buf #(.WIDTH(WIDTH)) u_redirect (
    .clk        (clk),
    .reset      (reset),
    .set        (pend_set),
    .clr        (pend_clr),
    .set_target (br_target),
    .valid      (pend_vld),
    .target     (pend_tgt)
  );

  // Next-pc selection. exc/eret ignore stall and fetch_ready; everything
  // else only advances on fire.
  always_comb begin
    ld       = 1'b0;
    pc_nxt   = pc;
    st_nxt   = state;
    pend_set = 1'b0;
    pend_clr = 1'b0;
    if (exc_valid) begin
      ld       = 1'b1;
      pc_nxt   = EXC_VEC;
      st_nxt   = RUN;
      pend_clr = 1'b1;
    end else if (eret_valid) begin
      ld       = 1'b1;
      pc_nxt   = epc;
      st_nxt   = RUN;
      pend_clr = 1'b1;
    end else if (state == BOOT) begin
      // Branches are dropped during the boot cycle.
      st_nxt = RUN;
    end else if (br_valid) begin
      if (fire) begin
        // Also covers PEND: the newer target supersedes the parked one.
        ld       = 1'b1;
        pc_nxt   = br_target;
        st_nxt   = RUN;
        pend_clr = 1'b1;
      end else begin
        pend_set = 1'b1;
        st_nxt   = PEND;
      end
    end else if (fire) begin
      ld       = 1'b1;
      st_nxt   = RUN;
      pend_clr = 1'b1;
      pc_nxt   = (state == PEND && pend_vld) ? pend_tgt : pc_plus;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= BOOT;
      pc          <= RESET_VEC;
      fetch_valid <= 1'b0;
      align_err   <= 1'b0;
    end else begin
      state       <= st_nxt;
      fetch_valid <= (st_nxt != BOOT);
      align_err   <= ld & misaligned;
      if (ld) pc <= pc_nxt;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Scenario bench for pc_unit: a 32-bit instance for the main flow and an
// 8-bit instance for the wrap case. Expected pc/flags are pushed to a
// scoreboard queue as each cycle's stimulus is driven and popped after the
// edge.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, br_valid, exc_valid, eret_valid, fetch_ready;
  logic [31:0] br_target, epc;
  logic        fetch_valid, align_err;
  logic [31:0] pc, pc_plus;

  logic       r8, st8, br8, exc8, eret8, fr8;
  logic [7:0] tgt8, epc8;
  logic       fv8, ae8;
  logic [7:0] pc8, pc_plus8;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] pc;
    logic        fv;
    logic        ae;
  } exp_t;

  typedef struct {
    logic        s, b, x, r, f, drop;
    logic [31:0] t, ep;
    exp_t        e;
  } row_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  pc_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .br_valid(br_valid),
    .br_target(br_target), .exc_valid(exc_valid), .eret_valid(eret_valid),
    .epc(epc), .fetch_ready(fetch_ready), .fetch_valid(fetch_valid),
    .pc(pc), .pc_plus(pc_plus), .align_err(align_err)
  );

  pc_unit #(.WIDTH(8), .RESET_VEC(8'hF0), .EXC_VEC(8'h80), .STEP(4)) dut8 (
    .clk(clk), .reset(r8), .stall(st8), .br_valid(br8),
    .br_target(tgt8), .exc_valid(exc8), .eret_valid(eret8),
    .epc(epc8), .fetch_ready(fr8), .fetch_valid(fv8),
    .pc(pc8), .pc_plus(pc_plus8), .align_err(ae8)
  );

  function automatic row_t mk(logic s, logic b, logic [31:0] t, logic x,
                              logic r, logic [31:0] ep, logic f,
                              logic [31:0] xpc, logic ae, logic drop = 1'b0);
    row_t w;
    w.s = s; w.b = b; w.t = t; w.x = x; w.r = r; w.ep = ep; w.f = f;
    w.drop = drop;
    w.e.pc = xpc; w.e.fv = 1'b1; w.e.ae = ae;
    return w;
  endfunction

  task automatic apply(input row_t w);
    stall = w.s; br_valid = w.b; br_target = w.t; exc_valid = w.x;
    eret_valid = w.r; epc = w.ep; fetch_ready = w.f;
  endtask

  task automatic test_reset();
    reset = 1'b1; r8 = 1'b1;
    stall = 0; br_valid = 0; br_target = 0; exc_valid = 0; eret_valid = 0;
    epc = 0; fetch_ready = 1'b1;
    st8 = 0; br8 = 0; tgt8 = 0; exc8 = 0; eret8 = 0; epc8 = 0; fr8 = 0;
    #1 reset = 1'b0; r8 = 1'b0;
    #2;
    n_checks++;
    if (pc !== 32'h3000 || pc_plus !== 32'h3004) begin
      n_fail++; $display("FAIL reset_pc got %h/%h want 3000/3004", pc, pc_plus);
    end
    n_checks++;
    if (fetch_valid !== 1'b0 || align_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags got fv=%b ae=%b want 0/0", fetch_valid, align_err);
    end
    n_checks++;
    if (pc8 !== 8'hF0 || fv8 !== 1'b0) begin
      n_fail++; $display("FAIL reset8 got pc=%h fv=%b want F0/0", pc8, fv8);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1; r8 = 1'b1;
    #1;
    n_checks++;
    if (pc !== 32'h3000 || fetch_valid !== 1'b0) begin
      n_fail++; $display("FAIL boot_cycle got pc=%h fv=%b want 3000/0", pc, fetch_valid);
    end
  endtask

  // Generic per-cycle table walk, duplicated per scenario so each test owns
  // its comparisons.
  task automatic test_boot_seq();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h3000, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h3004, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h3008, 0));
    foreach (rows[i]) begin
      apply(rows[i]); sb.push_back(rows[i].e);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (pc !== e.pc || pc_plus !== e.pc + 32'd4) begin
        n_fail++; $display("FAIL boot_seq[%0d] pc got %h/%h want %h", i, pc, pc_plus, e.pc);
      end
      n_checks++;
      if (fetch_valid !== e.fv || align_err !== e.ae) begin
        n_fail++; $display("FAIL boot_seq[%0d] fv/ae got %b%b want %b%b", i, fetch_valid, align_err, e.fv, e.ae);
      end
    end
  endtask

  task automatic test_stall_branch();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(1, 1, 32'h3100, 0, 0, 0, 1, 32'h3008, 0));
    rows.push_back(mk(1, 0, 32'h0,    0, 0, 0, 1, 32'h3008, 0));
    rows.push_back(mk(0, 0, 32'h0,    0, 0, 0, 1, 32'h3100, 0));
    foreach (rows[i]) begin
      apply(rows[i]); sb.push_back(rows[i].e);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (pc !== e.pc || pc_plus !== e.pc + 32'd4) begin
        n_fail++; $display("FAIL stall_branch[%0d] pc got %h/%h want %h", i, pc, pc_plus, e.pc);
      end
      n_checks++;
      if (fetch_valid !== e.fv || align_err !== e.ae) begin
        n_fail++; $display("FAIL stall_branch[%0d] fv/ae got %b%b want %b%b", i, fetch_valid, align_err, e.fv, e.ae);
      end
    end
  endtask

  task automatic test_pend_overwrite();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(1, 1, 32'h3300, 0, 0, 0, 1, 32'h3100, 0));
    rows.push_back(mk(1, 1, 32'h3200, 0, 0, 0, 1, 32'h3100, 0));
    rows.push_back(mk(0, 0, 32'h0,    0, 0, 0, 1, 32'h3200, 0));
    rows.push_back(mk(1, 1, 32'h3400, 0, 0, 0, 1, 32'h3200, 0));
    rows.push_back(mk(0, 1, 32'h3500, 0, 0, 0, 1, 32'h3500, 0));
    rows.push_back(mk(0, 0, 32'h0,    0, 0, 0, 1, 32'h3504, 0));
    foreach (rows[i]) begin
      apply(rows[i]); sb.push_back(rows[i].e);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (pc !== e.pc || pc_plus !== e.pc + 32'd4) begin
        n_fail++; $display("FAIL pend_overwrite[%0d] pc got %h/%h want %h", i, pc, pc_plus, e.pc);
      end
      n_checks++;
      if (fetch_valid !== e.fv || align_err !== e.ae) begin
        n_fail++; $display("FAIL pend_overwrite[%0d] fv/ae got %b%b want %b%b", i, fetch_valid, align_err, e.fv, e.ae);
      end
    end
  endtask

  task automatic test_exc_priority();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(1, 1, 32'h3600, 0, 0, 0,        1, 32'h3504, 0));
    rows.push_back(mk(1, 1, 32'h3700, 1, 1, 32'h3040, 1, 32'h4180, 0));
    rows.push_back(mk(0, 0, 32'h0,    0, 0, 0,        1, 32'h4184, 0));
    rows.push_back(mk(1, 0, 32'h0,    0, 1, 32'h3040, 1, 32'h3040, 0));
    rows.push_back(mk(0, 0, 32'h0,    0, 0, 0,        1, 32'h3044, 0));
    rows.push_back(mk(0, 1, 32'h3800, 0, 0, 0,        0, 32'h3044, 0));
    rows.push_back(mk(0, 0, 32'h0,    0, 0, 0,        1, 32'h3800, 0));
    rows.push_back(mk(0, 1, 32'h3900, 0, 1, 32'h3040, 1, 32'h3040, 0));
    rows.push_back(mk(0, 0, 32'h0,    0, 0, 0,        1, 32'h3044, 0));
    foreach (rows[i]) begin
      apply(rows[i]); sb.push_back(rows[i].e);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (pc !== e.pc || pc_plus !== e.pc + 32'd4) begin
        n_fail++; $display("FAIL exc_priority[%0d] pc got %h/%h want %h", i, pc, pc_plus, e.pc);
      end
      n_checks++;
      if (fetch_valid !== e.fv || align_err !== e.ae) begin
        n_fail++; $display("FAIL exc_priority[%0d] fv/ae got %b%b want %b%b", i, fetch_valid, align_err, e.fv, e.ae);
      end
    end
  endtask

  task automatic test_align();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(0, 1, 32'h3102, 0, 0, 0, 1, 32'h3102, 1));
    rows.push_back(mk(1, 0, 32'h0,    0, 0, 0, 1, 32'h3102, 0));
    rows.push_back(mk(1, 1, 32'h3200, 0, 0, 0, 1, 32'h3102, 0));
    rows.push_back(mk(0, 0, 32'h0,    0, 0, 0, 1, 32'h3200, 0));
    foreach (rows[i]) begin
      apply(rows[i]); sb.push_back(rows[i].e);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (pc !== e.pc || pc_plus !== e.pc + 32'd4) begin
        n_fail++; $display("FAIL align[%0d] pc got %h/%h want %h", i, pc, pc_plus, e.pc);
      end
      n_checks++;
      if (fetch_valid !== e.fv || align_err !== e.ae) begin
        n_fail++; $display("FAIL align[%0d] fv/ae got %b%b want %b%b", i, fetch_valid, align_err, e.fv, e.ae);
      end
    end
  endtask

  // Rows flagged drop: reset is pulled low mid-cycle after the row is
  // checked, then released so the next row lands in the boot cycle.
  task automatic test_reset_pend();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(1, 1, 32'h3900, 0, 0, 0, 1, 32'h3200, 0, 1));
    rows.push_back(mk(0, 1, 32'h3A00, 0, 0, 0, 1, 32'h3000, 0));
    rows.push_back(mk(0, 0, 32'h0,    0, 0, 0, 1, 32'h3004, 0, 1));
    rows.push_back(mk(0, 0, 32'h0,    1, 0, 0, 1, 32'h4180, 0));
    rows.push_back(mk(0, 0, 32'h0,    0, 0, 0, 1, 32'h4184, 0));
    foreach (rows[i]) begin
      apply(rows[i]); sb.push_back(rows[i].e);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (pc !== e.pc || pc_plus !== e.pc + 32'd4) begin
        n_fail++; $display("FAIL reset_pend[%0d] pc got %h/%h want %h", i, pc, pc_plus, e.pc);
      end
      n_checks++;
      if (fetch_valid !== e.fv || align_err !== e.ae) begin
        n_fail++; $display("FAIL reset_pend[%0d] fv/ae got %b%b want %b%b", i, fetch_valid, align_err, e.fv, e.ae);
      end
      if (rows[i].drop) begin
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (pc !== 32'h3000 || fetch_valid !== 1'b0 || pc_plus !== 32'h3004) begin
          n_fail++; $display("FAIL async_reset[%0d] got pc=%h fv=%b want 3000/0", i, pc, fetch_valid);
        end
        @(posedge clk); #1 reset = 1'b1;
      end
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    logic [7:0] x8 = 8'hF0;
    n_checks++;
    if (pc8 !== 8'hF0 || fv8 !== 1'b1) begin
      n_fail++; $display("FAIL wrap_hold got pc=%h fv=%b want F0/1", pc8, fv8);
    end
    st8 = 1'b0; fr8 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      x8 = x8 + 8'd4;
      e.pc = {24'h0, x8}; e.fv = 1'b1; e.ae = 1'b0;
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (pc8 !== e.pc[7:0] || pc_plus8 !== e.pc[7:0] + 8'd4) begin
        n_fail++; $display("FAIL wrap[%0d] pc got %h/%h want %h", k, pc8, pc_plus8, e.pc[7:0]);
      end
      n_checks++;
      if (fv8 !== e.fv || ae8 !== e.ae) begin
        n_fail++; $display("FAIL wrap[%0d] fv/ae got %b%b want %b%b", k, fv8, ae8, e.fv, e.ae);
      end
    end
    #2 r8 = 1'b0;
    #1;
    n_checks++;
    if (pc8 !== 8'hF0 || fv8 !== 1'b0 || pc_plus8 !== 8'hF4) begin
      n_fail++; $display("FAIL wrap_async_reset got pc=%h fv=%b want F0/0", pc8, fv8);
    end
  endtask

  initial begin
    test_reset();
    test_boot_seq();
    test_stall_branch();
    test_pend_overwrite();
    test_exc_priority();
    test_align();
    test_reset_pend();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
